// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and helpers for the BTB/RAS branch predictor
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    BT_COND = 2'd0,
    BT_JUMP = 2'd1,
    BT_CALL = 2'd2,
    BT_RET  = 2'd3
  } branch_type_t;

  typedef logic [1:0] bp_cnt_t;

  // Tag is kept at full width so one struct fits every ENTRIES setting.
  typedef struct packed {
    logic         valid;
    logic [31:0]  tag;
    logic [31:0]  target;
    branch_type_t btype;
    bp_cnt_t      cnt;
  } btb_entry_t;

  function automatic bp_cnt_t cnt_step(input bp_cnt_t c, input logic up);
    if (up) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and MEMORY-stage resolve bundle
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic [31:0]  fetch_pc;
  logic         fetch_predict;
  logic [31:0]  fetch_target;
  logic         mem_en;
  logic         mem_branch;
  branch_type_t mem_type;
  logic [31:0]  mem_pc;
  logic         mem_predict;
  logic [31:0]  mem_target;
  logic         mem_taken;
  logic [31:0]  mem_target_res;
  logic         mem_branch_miss;
  logic         mem_flush;

  modport master (
    output fetch_pc, mem_en, mem_branch, mem_type, mem_pc, mem_predict,
           mem_target, mem_taken, mem_target_res,
    input  fetch_predict, fetch_target, mem_branch_miss, mem_flush
  );

  modport slave (
    input  fetch_pc, mem_en, mem_branch, mem_type, mem_pc, mem_predict,
           mem_target, mem_taken, mem_target_res,
    output fetch_predict, fetch_target, mem_branch_miss, mem_flush
  );
endinterface

// File: rtl/branch_predictor_ras_stack.sv
// rtl/branch_predictor_ras_stack.sv - circular return address stack, oldest slot lost on overflow
module ras_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;

  // ptr_q is the next free slot; the top of stack sits one slot behind it.
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - 1'b1;
  assign top     = mem_q[ptr_dec];
  assign empty   = (cnt_q == '0);

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_inc;
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and commit-time RAS
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_INIT  = 2,
  parameter int DYNAMIC   = 1
) (
  input logic clk,
  input logic nrst,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t       btb_q [ENTRIES];
  btb_entry_t       btb_d [ENTRIES];
  logic [IDX_W-1:0] f_idx, m_idx;
  logic [31:0]      f_tag, m_tag;
  btb_entry_t       f_ent, m_ent;
  logic             f_hit, m_hit, miss;
  logic             ras_push, ras_pop, ras_empty;
  logic [31:0]      ras_top;

  assign f_idx = IDX_W'(bp.fetch_pc >> 2);
  assign f_tag = bp.fetch_pc >> (IDX_W + 2);
  assign m_idx = IDX_W'(bp.mem_pc >> 2);
  assign m_tag = bp.mem_pc >> (IDX_W + 2);
  assign f_ent = btb_q[f_idx];
  assign m_ent = btb_q[m_idx];
  assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
  assign m_hit = m_ent.valid && (m_ent.tag == m_tag);

  always_comb begin
    bp.fetch_predict = f_hit && ((f_ent.btype != BT_COND) || (DYNAMIC == 0) || f_ent.cnt[1]);
    bp.fetch_target  = '0;
    if (bp.fetch_predict)
      bp.fetch_target = (f_ent.btype == BT_RET && !ras_empty) ? ras_top : f_ent.target;
  end

  // A non-branch arriving with a prediction means fetch hit an aliased entry.
  always_comb begin
    miss = 1'b0;
    if (bp.mem_en) begin
      if (bp.mem_branch)
        miss = (bp.mem_predict != bp.mem_taken) ||
               (bp.mem_taken && (bp.mem_target != bp.mem_target_res));
      else
        miss = bp.mem_predict;
    end
  end

  assign bp.mem_branch_miss = miss;
  assign bp.mem_flush       = miss;

  always_comb begin
    btb_d = btb_q;
    if (bp.mem_en) begin
      if (bp.mem_branch) begin
        if (m_hit) begin
          btb_d[m_idx].cnt    = cnt_step(m_ent.cnt, bp.mem_taken);
          btb_d[m_idx].target = bp.mem_target_res;
          btb_d[m_idx].btype  = bp.mem_type;
        end else if (bp.mem_taken) begin
          btb_d[m_idx] = '{valid: 1'b1, tag: m_tag, target: bp.mem_target_res,
                           btype: bp.mem_type, cnt: bp_cnt_t'(CNT_INIT)};
        end
      end else if (bp.mem_predict) begin
        btb_d[m_idx].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < ENTRIES; i++)
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, btype: BT_COND,
                      cnt: bp_cnt_t'(CNT_INIT)};
    end else begin
      btb_q <= btb_d;
    end
  end

  assign ras_push = bp.mem_en && bp.mem_branch && (bp.mem_type == BT_CALL);
  assign ras_pop  = bp.mem_en && bp.mem_branch && (bp.mem_type == BT_RET);

  generate
    if (RAS_DEPTH > 0) begin : g_ras
      ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .nrst      (nrst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (bp.mem_pc + 32'd4),
        .top       (ras_top),
        .empty     (ras_empty)
      );
    end else begin : g_no_ras
      assign ras_top   = '0;
      assign ras_empty = 1'b1;
    end
  endgenerate
endmodule
